// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer state encoding, datapath widths and the
// default reset vector.
package cpu_pkg;

  localparam int unsigned PC_WIDTH      = 16;
  localparam int unsigned INSTR_W       = 16;
  localparam logic [15:0] RESET_VEC_DEF = 16'h0000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    UPDATE = 3'd4
  } seq_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: synchronous active-high reset to RESET_VEC,
// loaded with ld_val_i whenever ld_en_i is high.
module pc_reg
  import cpu_pkg::*;
#(
  parameter int unsigned       PC_W      = PC_WIDTH,
  parameter logic [PC_W-1:0]   RESET_VEC = PC_W'(RESET_VEC_DEF)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ld_en_i,
  input  logic [PC_W-1:0] ld_val_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q;

  always_ff @(posedge clk) begin
    if (reset)        pc_q <= RESET_VEC;
    else if (ld_en_i) pc_q <= ld_val_i;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/pc_sequencer.sv
// Instruction sequencer: FETCH/DECODE/EXEC/UPDATE FSM, instruction register,
// next-PC selection. Define PC_SEQ_LINK_EN to enable the jump-and-link register.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W      = PC_WIDTH,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(RESET_VEC_DEF)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] ir,
  output logic               ex_start,
  input  logic               ex_done,
  input  logic               br_take,
  input  logic [PC_W-1:0]    br_target,
  input  logic               link_req,
  output logic [PC_W-1:0]    pc,
  output logic               en_pc,
  output logic [PC_W-1:0]    link,
  output logic               link_we,
  output logic               busy
);

  seq_state_e         state_q, state_d;
  logic [INSTR_W-1:0] ir_q;
  logic               br_take_q;
  logic [PC_W-1:0]    br_target_q;
  logic [PC_W-1:0]    pc_inc;
  logic [PC_W-1:0]    pc_next;

  assign pc_inc  = pc + PC_W'(1);
  assign pc_next = br_take_q ? br_target_q : pc_inc;

  pc_reg #(
    .PC_W      (PC_W),
    .RESET_VEC (RESET_VEC)
  ) u_pc_reg (
    .clk      (clk),
    .reset    (reset),
    .ld_en_i  (en_pc),
    .ld_val_i (pc_next),
    .pc_o     (pc)
  );

`ifdef PC_SEQ_LINK_EN
  logic            link_req_q;
  logic [PC_W-1:0] link_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      link_req_q <= 1'b0;
      link_q     <= '0;
    end else begin
      if (state_q == EXEC && ex_done) link_req_q <= link_req;
      if (link_we)                    link_q     <= pc_inc;
    end
  end

  assign link = link_q;
`else
  logic link_req_unused;
  assign link_req_unused = link_req;
  assign link            = '0;
`endif

  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    ex_start = 1'b0;
    en_pc    = 1'b0;
    link_we  = 1'b0;
    busy     = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (run) state_d = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_d = DECODE;
      end
      DECODE: begin
        ex_start = 1'b1;
        state_d  = EXEC;
      end
      EXEC: begin
        if (ex_done) state_d = UPDATE;
      end
      UPDATE: begin
        en_pc = 1'b1;
`ifdef PC_SEQ_LINK_EN
        link_we = br_take_q & link_req_q;
`endif
        state_d = run ? FETCH : IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ir_q        <= '0;
      br_take_q   <= 1'b0;
      br_target_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH && imem_ack) ir_q <= imem_data;
      if (state_q == EXEC && ex_done) begin
        br_take_q   <= br_take;
        br_target_q <= br_target;
      end
    end
  end

  assign ir        = ir_q;
  assign imem_addr = pc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; link expectations follow
// PC_SEQ_LINK_EN.
module tb_pc_sequencer;

  localparam int unsigned PC_W = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            run;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [15:0]     imem_data;
  logic [15:0]     ir;
  logic            ex_start;
  logic            ex_done;
  logic            br_take;
  logic [PC_W-1:0] br_target;
  logic            link_req;
  logic [PC_W-1:0] pc;
  logic            en_pc;
  logic [PC_W-1:0] link;
  logic            link_we;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  pc_sequencer #(
    .PC_W      (PC_W),
    .RESET_VEC (16'h0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .ir        (ir),
    .ex_start  (ex_start),
    .ex_done   (ex_done),
    .br_take   (br_take),
    .br_target (br_target),
    .link_req  (link_req),
    .pc        (pc),
    .en_pc     (en_pc),
    .link      (link),
    .link_we   (link_we),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; imem_ack = 1'b0; ex_done = 1'b0;
    br_take = 1'b0; br_target = '0; link_req = 1'b0; imem_data = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({busy, imem_req, ex_start, en_pc, link_we} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b want 00000", {busy, imem_req, ex_start, en_pc, link_we});
    end
    n_checks++;
    if (pc !== 16'h0000 || ir !== 16'h0000 || link !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_regs: pc=%h ir=%h link=%h want 0000 0000 0000", pc, ir, link);
    end
    step();
    n_checks++;
    if (busy !== 1'b0 || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_hold: busy=%b req=%b want 0 0", busy, imem_req);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    run = 1'b1; imem_ack = 1'b1; ex_done = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      imem_data = 16'h1000 + 16'(i);
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 16'(i)) begin
        n_fail++;
        $display("FAIL seq_fetch%0d: req=%b addr=%h want 1 %h", i, imem_req, imem_addr, 16'(i));
      end
      step();
      n_checks++;
      if (ex_start !== 1'b1 || ir !== 16'h1000 + 16'(i) || en_pc !== 1'b0) begin
        n_fail++;
        $display("FAIL seq_decode%0d: ex_start=%b ir=%h en_pc=%b want 1 %h 0", i, ex_start, ir, en_pc, 16'h1000 + 16'(i));
      end
      step();
      step();
      n_checks++;
      if (en_pc !== 1'b1 || pc !== 16'(i) || ex_start !== 1'b0) begin
        n_fail++;
        $display("FAIL seq_update%0d: en_pc=%b pc=%h ex_start=%b want 1 %h 0", i, en_pc, pc, ex_start, 16'(i));
      end
      step();
    end
  endtask

  task automatic test_fetch_stall();
    do_reset();
    run = 1'b1; imem_ack = 1'b1; ex_done = 1'b1; br_take = 1'b1; br_target = 16'h0005;
    imem_data = 16'h1111;
    step(); step(); step(); step();
    imem_ack = 1'b0; br_take = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        imem_ack  = 1'b1;
        imem_data = 16'hABCD;
      end
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0005 || ir !== 16'h1111 || ex_start !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_wait%0d: req=%b addr=%h ir=%h ex_start=%b want 1 0005 1111 0", k, imem_req, imem_addr, ir, ex_start);
      end
      step();
    end
    n_checks++;
    if (ex_start !== 1'b1 || ir !== 16'hABCD || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_decode: ex_start=%b ir=%h req=%b want 1 abcd 0", ex_start, ir, imem_req);
    end
    step();
    n_checks++;
    if (ex_start !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_single_start: ex_start=%b want 0", ex_start);
    end
  endtask

  task automatic test_branch_wrap();
    do_reset();
    run = 1'b1; imem_ack = 1'b1; ex_done = 1'b1; br_take = 1'b1; br_target = 16'hFFFF;
    step(); step(); step(); step();
    br_take = 1'b0; br_target = 16'h1234;
    step();
    n_checks++;
    if (imem_addr !== 16'hFFFF || pc !== 16'hFFFF || imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL branch_target: addr=%h pc=%h req=%b want ffff ffff 1", imem_addr, pc, imem_req);
    end
    step(); step(); step();
    n_checks++;
    if (en_pc !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_en_pc: en_pc=%b want 1", en_pc);
    end
    step();
    n_checks++;
    if (pc !== 16'h0000 || imem_addr !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap_pc: pc=%h addr=%h want 0000 0000", pc, imem_addr);
    end
  endtask

  task automatic test_reset_in_exec();
    do_reset();
    run = 1'b1; imem_ack = 1'b1; ex_done = 1'b1; br_take = 1'b1; br_target = 16'h0040;
    step(); step(); step(); step();
    ex_done = 1'b0;
    step(); step(); step(); step();
    n_checks++;
    if (pc !== 16'h0040 || busy !== 1'b1 || en_pc !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_exec_wait: pc=%h busy=%b en_pc=%b want 0040 1 0", pc, busy, en_pc);
    end
    reset = 1'b1;
    step();
    reset = 1'b0; run = 1'b0; ex_done = 1'b1;
    n_checks++;
    if (busy !== 1'b0 || pc !== 16'h0000 || ir !== 16'h0000 || {imem_req, ex_start, en_pc, link_we} !== 4'b0) begin
      n_fail++;
      $display("FAIL rst_exec_after: busy=%b pc=%h ir=%h strobes=%b want 0 0000 0000 0000", busy, pc, ir, {imem_req, ex_start, en_pc, link_we});
    end
    step();
    n_checks++;
    if (en_pc !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_exec_done_ignored: en_pc=%b busy=%b want 0 0", en_pc, busy);
    end
    step();
    n_checks++;
    if (en_pc !== 1'b0 || pc !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_exec_pc_hold: en_pc=%b pc=%h want 0 0000", en_pc, pc);
    end
  endtask

  task automatic test_run_drop();
    int activity;
    do_reset();
    run = 1'b1; imem_ack = 1'b0; ex_done = 1'b1;
    step();
    run = 1'b0;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      n_fail++;
      $display("FAIL drop_fetch: req=%b addr=%h want 1 0000", imem_req, imem_addr);
    end
    step();
    imem_ack = 1'b1;
    step(); step(); step();
    n_checks++;
    if (en_pc !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_update: en_pc=%b want 1", en_pc);
    end
    step();
    n_checks++;
    if (busy !== 1'b0 || imem_req !== 1'b0 || pc !== 16'h0001) begin
      n_fail++;
      $display("FAIL drop_idle: busy=%b req=%b pc=%h want 0 0 0001", busy, imem_req, pc);
    end
    activity = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      activity += int'(imem_req) + int'(en_pc) + int'(busy);
    end
    n_checks++;
    if (activity !== 0) begin
      n_fail++;
      $display("FAIL drop_parked: active strobe cycles=%0d want 0", activity);
    end
    run = 1'b1;
    step();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0001) begin
      n_fail++;
      $display("FAIL drop_resume: req=%b addr=%h want 1 0001", imem_req, imem_addr);
    end
  endtask

  task automatic test_link();
    logic [15:0] exp_link;
    logic        exp_we;
    int          we_count;
`ifdef PC_SEQ_LINK_EN
    exp_link = 16'h0011; exp_we = 1'b1;
`else
    exp_link = 16'h0000; exp_we = 1'b0;
`endif
    we_count = 0;
    do_reset();
    run = 1'b1; imem_ack = 1'b1; ex_done = 1'b1; br_take = 1'b1; br_target = 16'h0010;
    for (int c = 0; c < 4; c++) begin
      step();
      we_count += int'(link_we);
    end
    br_target = 16'h0200; link_req = 1'b1;
    step();
    we_count += int'(link_we);
    n_checks++;
    if (imem_addr !== 16'h0010 || link !== 16'h0000) begin
      n_fail++;
      $display("FAIL link_setup: addr=%h link=%h want 0010 0000", imem_addr, link);
    end
    step(); step(); step();
    we_count += int'(link_we);
    n_checks++;
    if (en_pc !== 1'b1 || link_we !== exp_we) begin
      n_fail++;
      $display("FAIL link_we_pulse: en_pc=%b link_we=%b want 1 %b", en_pc, link_we, exp_we);
    end
    run = 1'b0; link_req = 1'b0; br_take = 1'b0;
    step();
    we_count += int'(link_we);
    n_checks++;
    if (pc !== 16'h0200 || link !== exp_link || link_we !== 1'b0) begin
      n_fail++;
      $display("FAIL link_value: pc=%h link=%h link_we=%b want 0200 %h 0", pc, link, link_we, exp_link);
    end
    step();
    we_count += int'(link_we);
    n_checks++;
    if (we_count !== int'(exp_we) || link !== exp_link) begin
      n_fail++;
      $display("FAIL link_hold: link_we count=%0d link=%h want %0d %h", we_count, link, int'(exp_we), exp_link);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_fetch_stall();
    test_branch_wrap();
    test_reset_in_exec();
    test_run_drop();
    test_link();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Instruction sequencer for the 16-bit CPU. It owns the program counter and steps it through FETCH, DECODE, EXECUTE and UPDATE: instruction memory handshake, instruction register load, execute start/done handshake with the datapath, and next-PC selection. Next PC is either sequential (+1) or a taken branch target. It sits between instruction memory and the datapath/ALU control, and its `en_pc` strobe marks every architectural PC update.

## Interface
- `PC_W`, default 16: PC and instruction-address width.
- `RESET_VEC`, default 16'h0000: PC value loaded on reset.
- `clk`  in  1: the single clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `run`  in  1: sequencing enable; sampled in IDLE and UPDATE.
- `imem_req`  out  1: instruction fetch request.
- `imem_addr`  out  PC_W: fetch address, equal to `pc`.
- `imem_ack`  in  1: fetch complete; `imem_data` valid this cycle.
- `imem_data`  in  16: fetched instruction.
- `ir`  out  16: instruction register.
- `ex_start`  out  1: one-cycle pulse telling the datapath to execute `ir`.
- `ex_done`  in  1: datapath finished; qualifies `br_take`, `br_target` and `link_req`.
- `br_take`  in  1: branch taken.
- `br_target`  in  PC_W: branch destination.
- `link_req`  in  1: jump-and-link request, effective only with `br_take`.
- `pc`  out  PC_W: current program counter.
- `en_pc`  out  1: one-cycle pulse in the cycle `pc` takes a new value.
- `link`  out  PC_W: return address register.
- `link_we`  out  1: one-cycle pulse when `link` is written.
- `busy`  out  1: high in every state except IDLE.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, UPDATE.
- All strobes are Moore outputs decoded from registered state.
- IDLE: all strobes 0. Goes to FETCH when `run`=1.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`, both held stable until `imem_ack`.
  - On `imem_ack`: `ir` <= `imem_data`, go to DECODE.
- DECODE: exactly one cycle with `ex_start`=1, then EXEC.
- EXEC: wait for `ex_done`. On `ex_done`, register `br_take`, `br_target` and `link_req`, then go to UPDATE.
- UPDATE:
  - `pc` <= taken ? target : `pc`+1, with `en_pc`=1.
  - Next state is FETCH if `run`=1, else IDLE.
- Arithmetic: `pc`+1 is modulo 2^PC_W, so 0xFFFF+1 = 0x0000 with no flag. A branch to the current PC is legal.
- Ignored inputs: `imem_ack` outside FETCH and `ex_done` outside EXEC have no effect.
- `run` deasserted mid-instruction: the current instruction completes through UPDATE, then the sequencer parks in IDLE.
- Reset (any state, including mid-handshake):
  - State returns to IDLE; `pc`=RESET_VEC; `ir`=0; `link`=0.
  - `imem_req`, `ex_start`, `en_pc`, `link_we` and `busy` are all 0 in the cycle after the reset edge.
  - Reset takes priority over every other input.

## Timing
- Minimum of 4 cycles per instruction (FETCH, DECODE, EXEC, UPDATE) when `imem_ack` and `ex_done` each arrive in the first cycle of their state.
- Each cycle of `imem_ack` wait adds one cycle; each cycle of `ex_done` wait adds one cycle.
- `ex_start` rises the cycle after the `imem_ack` edge.
- `en_pc` rises the cycle after the `ex_done` edge.
- The new `pc` is visible on `imem_addr` in the FETCH cycle that directly follows UPDATE.
- The first `imem_req` appears 1 cycle after `run` is sampled high in IDLE.

## Configuration
- `PC_SEQ_LINK_EN` defined:
  - In UPDATE with taken && `link_req`: `link` <= `pc`+1 (wrapped) and `link_we`=1 for one cycle.
  - `link` holds its value otherwise.
- `PC_SEQ_LINK_EN` undefined:
  - `link` is tied to 0 and `link_we` to 0.
  - `link_req` is ignored.
  - The port list is identical in both builds.

## Structure
- Shared package `cpu_pkg`:
  - sequencer state enum (IDLE=0, FETCH=1, DECODE=2, EXEC=3, UPDATE=4, 3-bit encoding);
  - `PC_W` and instruction width (16) constants;
  - default `RESET_VEC`.
- One sub-module, `pc_reg`: a PC_W-bit register with synchronous active-high reset to RESET_VEC, load enable and load value. The sequencer drives its load enable with `en_pc` and computes the next-PC mux itself.
- Everything else (FSM, `ir`, link logic) lives in `pc_sequencer`.

## Test plan
1. Sequential run: reset, `run`=1, immediate `imem_ack` and `ex_done`, `br_take`=0 -> `imem_addr` 0x0000, 0x0001, 0x0002 on successive fetches; `en_pc` pulses every 4 cycles.
2. Fetch stall: `pc`=0x0005 with `imem_ack` delayed 3 cycles -> `imem_req`=1 and `imem_addr`=0x0005 stable for 4 cycles; `ir` becomes 0xABCD only after the ack cycle; `ex_start` pulses once.
3. Branch and wrap: `ex_done` with `br_take`=1, `br_target`=0xFFFF -> next fetch at 0xFFFF; then not-taken -> `pc`=0x0000.
4. Reset in EXEC: assert `reset` while waiting on `ex_done` -> next cycle state IDLE, `pc`=RESET_VEC, `busy`=0; `ex_done` one cycle later causes no `en_pc`.
5. Run drop: deassert `run` during FETCH -> the instruction completes with one `en_pc`, then IDLE and no further `imem_req`; re-assert `run` -> fetch resumes at the updated `pc`.
6. Link, with `PC_SEQ_LINK_EN`: at `pc`=0x0010, `br_take`=1, `link_req`=1, `br_target`=0x0200 -> `link`=0x0011 and `link_we` high for 1 cycle, `pc`=0x0200. Without the macro: `link` stays 0 and `link_we` never asserts.
